// File: rtl/acondicionador_sensores_if.sv
// Sensor-conditioning signal bundle: raw sensor inputs toward the conditioner and
// conditioned flags toward the fire-control FSM.
interface acondicionador_sensores_if;
  logic [7:0] TempDato;
  logic       TempValido;
  logic       HumoRaw;
  logic       CSRaw;
  logic       Humo;
  logic       T1;
  logic       T2;
  logic       CS;
  logic       SensorFalla;

  // Sensor / stimulus side
  modport master (
    output TempDato, TempValido, HumoRaw, CSRaw,
    input  Humo, T1, T2, CS, SensorFalla
  );

  // Conditioner side
  modport slave (
    input  TempDato, TempValido, HumoRaw, CSRaw,
    output Humo, T1, T2, CS, SensorFalla
  );
endinterface

// File: rtl/acondicionador_sensores.sv
// Sensor conditioner: synchronizes and debounces smoke/short contacts, applies
// hysteresis thresholds to temperature samples and flags a stalled temperature sensor.

// Two-flop synchronizer followed by a two-state debouncer for one raw contact.
module acond_debounce #(
  parameter logic [15:0] DEB_CICLOS = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {ESTABLE, CONTANDO} deb_state_e;

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             out_q, out_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ESTABLE;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
    end
  end

  // The first differing sample is seen in ESTABLE, so leaving it already counts one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sync1_d = raw;
    sync2_d = sync1_q;
    case (state_q)
      ESTABLE: begin
        cnt_d = '0;
        if (sync2_q != out_q) begin
          if (DEB_CICLOS <= CNT_W'(1)) begin
            out_d = sync2_q;
          end else begin
            state_d = CONTANDO;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CONTANDO: begin
        if (sync2_q == out_q) begin
          state_d = ESTABLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_CICLOS - CNT_W'(1)) begin
          state_d = ESTABLE;
          cnt_d   = '0;
          out_d   = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ESTABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign deb = out_q;
endmodule

module acondicionador_sensores #(
  parameter logic [7:0]  UMBRAL_ALTO  = 8'd60,
  parameter logic [7:0]  UMBRAL_MEDIO = 8'd40,
  parameter logic [7:0]  HIST         = 8'd2,
  parameter logic [15:0] DEB_CICLOS   = 16'd50000,
  parameter logic [19:0] TIMEOUT      = 20'd1000000
) (
  input  logic                      Clk,
  input  logic                      Reset,
  acondicionador_sensores_if.slave  bus
);
  localparam int unsigned TEMP_W = 8;
  localparam int unsigned WD_W   = 20;

  // Clear levels saturate at 0; a zero level can never be undercut, so the flag sticks.
  localparam logic [TEMP_W-1:0] LIM_ALTO  =
    (UMBRAL_ALTO > HIST) ? TEMP_W'(UMBRAL_ALTO - HIST) : '0;
  localparam logic [TEMP_W-1:0] LIM_MEDIO =
    (UMBRAL_MEDIO > HIST) ? TEMP_W'(UMBRAL_MEDIO - HIST) : '0;

  logic [TEMP_W-1:0] temp_reg_q, temp_reg_d;
  logic              fa_q, fa_d;
  logic              fm_q, fm_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              falla_q, falla_d;
  logic              t1_q, t1_d;
  logic              t2_q, t2_d;

  acond_debounce #(.DEB_CICLOS(DEB_CICLOS)) u_deb_humo (
    .clk   (Clk),
    .reset (Reset),
    .raw   (bus.HumoRaw),
    .deb   (bus.Humo)
  );

  acond_debounce #(.DEB_CICLOS(DEB_CICLOS)) u_deb_cs (
    .clk   (Clk),
    .reset (Reset),
    .raw   (bus.CSRaw),
    .deb   (bus.CS)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      temp_reg_q <= '0;
      fa_q       <= 1'b0;
      fm_q       <= 1'b0;
      wd_cnt_q   <= '0;
      falla_q    <= 1'b0;
      t1_q       <= 1'b0;
      t2_q       <= 1'b0;
    end else begin
      temp_reg_q <= temp_reg_d;
      fa_q       <= fa_d;
      fm_q       <= fm_d;
      wd_cnt_q   <= wd_cnt_d;
      falla_q    <= falla_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
    end
  end

  always_comb begin
    temp_reg_d = bus.TempValido ? bus.TempDato : temp_reg_q;

    fa_d = fa_q;
    if (temp_reg_q >= UMBRAL_ALTO) begin
      fa_d = 1'b1;
    end else if (temp_reg_q < LIM_ALTO) begin
      fa_d = 1'b0;
    end

    fm_d = fm_q;
    if (temp_reg_q >= UMBRAL_MEDIO) begin
      fm_d = 1'b1;
    end else if (temp_reg_q < LIM_MEDIO) begin
      fm_d = 1'b0;
    end

    // A fresh sample always beats the watchdog expiring on the same edge.
    wd_cnt_d = wd_cnt_q;
    falla_d  = falla_q;
    if (bus.TempValido) begin
      wd_cnt_d = '0;
      falla_d  = 1'b0;
    end else if (wd_cnt_q < TIMEOUT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
      if (wd_cnt_d == TIMEOUT) begin
        falla_d = 1'b1;
      end
    end else begin
      falla_d = 1'b1;
    end

    // A dead sensor is treated as full temperature.
    t1_d = fa_d | falla_d;
    t2_d = fm_d | falla_d;
  end

  assign bus.T1          = t1_q;
  assign bus.T2          = t2_q;
  assign bus.SensorFalla = falla_q;
endmodule
